// File: rtl/hs_sync_detector_if.sv
// Byte-clock bus between the HS deserializer side and the sync detector.
// The master drives the enable/raw byte; the slave returns sync status and aligned payload.
interface hs_sync_detector_if;
    logic       Enable;
    logic [7:0] DataHS;
    logic       Zero_Detected;
    logic       RxSyncHS;
    logic       SyncErr;
    logic [2:0] Offset;
    logic [7:0] RxDataHS;
    logic       RxValidHS;

    modport master (
        output Enable, DataHS,
        input  Zero_Detected, RxSyncHS, SyncErr, Offset, RxDataHS, RxValidHS
    );

    modport slave (
        input  Enable, DataHS,
        output Zero_Detected, RxSyncHS, SyncErr, Offset, RxDataHS, RxValidHS
    );
endinterface

// File: rtl/hs_sync_detector.sv
// D-PHY HS sync detector: HS-zero run detection, leader search at any bit offset, aligned payload.
// Define SYNC_1BIT_ERR_TOL_EN to also accept a leader with a single flipped bit.
module hs_sync_detector #(
    parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
    parameter int unsigned ZERO_BITS    = 8
) (
    input logic              RxByteClkHS,
    input logic              Rst,
    hs_sync_detector_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ZERO, ARMED, PEND, LOCKED} state_t;

    localparam logic [5:0] ZB = 6'(ZERO_BITS);

    state_t      state_q, state_d;
    logic [7:0]  prev_q;
    logic [5:0]  run_q, run_d, run_next;
    logic        zd_q, zd_d;
    logic        sync_q, sync_d;
    logic        err_q, err_d;
    logic [2:0]  offset_q, offset_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic        rxvalid_q, rxvalid_d;
    logic [15:0] w;
    logic [3:0]  lock;

    function automatic logic [5:0] sat_run(input logic [5:0] r);
        logic [6:0] s;
        s = {1'b0, r} + 7'd8;
        return (s > 7'd63) ? 6'd63 : s[5:0];
    endfunction

    function automatic logic [5:0] lead_zeros(input logic [7:0] d);
        logic [5:0] n;
        logic       stop;
        n    = '0;
        stop = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!stop) begin
                if (!d[i]) n = n + 6'd1;
                else       stop = 1'b1;
            end
        end
        return n;
    endfunction

    // Bits below the candidate offset must be zero so the leader is preceded by HS-zero.
    function automatic logic zero_below(input logic [15:0] win, input int k);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
            if (win[j]) ok = 1'b0;
        end
        return ok;
    endfunction

    // Returns {found, k}; descending scan so the lowest offset wins.
    function automatic logic [3:0] find_lock(input logic [15:0] win);
        logic [3:0] r;
        r = '0;
        for (int k = 7; k >= 0; k--) begin
            if (win[k +: 8] == SYNC_PATTERN && zero_below(win, k)) r = {1'b1, k[2:0]};
        end
`ifdef SYNC_1BIT_ERR_TOL_EN
        if (!r[3]) begin
            for (int k = 7; k >= 0; k--) begin
                if ($countones(win[k +: 8] ^ SYNC_PATTERN) == 1 && zero_below(win, k))
                    r = {1'b1, k[2:0]};
            end
        end
`else
`endif
        return r;
    endfunction

    always_comb begin
        w         = {bus.DataHS, prev_q};
        lock      = find_lock(w);
        run_next  = (bus.DataHS == 8'h00) ? sat_run(run_q) : lead_zeros(bus.DataHS);
        state_d   = state_q;
        run_d     = run_q;
        offset_d  = offset_q;
        rxdata_d  = rxdata_q;
        rxvalid_d = 1'b0;
        sync_d    = 1'b0;
        err_d     = 1'b0;
        if (!bus.Enable) begin
            state_d  = IDLE;
            run_d    = '0;
            rxdata_d = '0;
        end else begin
            run_d = run_next;
            case (state_q)
                IDLE, ZERO: state_d = (run_next >= ZB) ? ARMED : ZERO;
                ARMED, PEND: begin
                    if (lock[3]) begin
                        sync_d   = 1'b1;
                        offset_d = lock[2:0];
                        state_d  = LOCKED;
                    end else if (state_q == PEND) begin
                        err_d   = 1'b1;
                        state_d = ZERO;
                    end else if (bus.DataHS != 8'h00) begin
                        state_d = PEND;
                    end
                end
                LOCKED: begin
                    rxdata_d  = w[offset_q +: 8];
                    rxvalid_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        zd_d = (state_d == ARMED) || (state_d == PEND);
    end

    always_ff @(posedge RxByteClkHS or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            run_q     <= '0;
            zd_q      <= 1'b0;
            sync_q    <= 1'b0;
            err_q     <= 1'b0;
            offset_q  <= '0;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= bus.DataHS;
            run_q     <= run_d;
            zd_q      <= zd_d;
            sync_q    <= sync_d;
            err_q     <= err_d;
            offset_q  <= offset_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
        end
    end

    assign bus.Zero_Detected = zd_q;
    assign bus.RxSyncHS      = sync_q;
    assign bus.SyncErr       = err_q;
    assign bus.Offset        = offset_q;
    assign bus.RxDataHS      = rxdata_q;
    assign bus.RxValidHS     = rxvalid_q;

endmodule

// File: tb/tb_hs_sync_detector.sv
// Bench for hs_sync_detector: directed sequences plus randomized packets against a behavioural model.
module tb_hs_sync_detector;

    localparam logic [7:0] PAT = 8'hB8;
    localparam int         ZB  = 8;
    localparam int M_IDLE = 0, M_ZERO = 1, M_ARMED = 2, M_PEND = 3, M_LOCKED = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    hs_sync_detector_if bus();

    hs_sync_detector #(.SYNC_PATTERN(PAT), .ZERO_BITS(ZB)) dut (
        .RxByteClkHS(clk),
        .Rst        (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_mode;
    int         m_run;
    logic [7:0] m_prev;
    logic       m_zd, m_sync, m_err, m_vld;
    logic [2:0] m_off;
    logic [7:0] m_data;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int zeros_from_top(input logic [7:0] d);
        int n = 0;
        while (n < 8 && d[7-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic int leader_at(input logic [15:0] w);
        for (int k = 0; k < 8; k++)
            if (((w >> k) & 16'h00FF) == {8'h00, PAT} && (w & ((16'h1 << k) - 16'h1)) == 16'h0)
                return k;
`ifdef SYNC_1BIT_ERR_TOL_EN
        for (int k = 0; k < 8; k++)
            if ($countones(((w >> k) & 16'h00FF) ^ {8'h00, PAT}) == 1 &&
                (w & ((16'h1 << k) - 16'h1)) == 16'h0)
                return k;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_run = 0; m_prev = 8'h00;
        m_zd = 0; m_sync = 0; m_err = 0; m_vld = 0; m_off = 3'd0; m_data = 8'h00;
    endtask

    task automatic model_step(input logic en, input logic [7:0] d);
        logic [15:0] w;
        int          k, nrun;
        w      = {d, m_prev};
        m_sync = 0;
        m_err  = 0;
        m_vld  = 0;
        if (!en) begin
            m_mode = M_IDLE; m_run = 0; m_data = 8'h00;
        end else begin
            nrun = (d == 8'h00) ? ((m_run + 8 > 63) ? 63 : m_run + 8) : zeros_from_top(d);
            if (m_mode == M_IDLE || m_mode == M_ZERO) begin
                m_mode = (nrun >= ZB) ? M_ARMED : M_ZERO;
            end else if (m_mode == M_ARMED || m_mode == M_PEND) begin
                k = leader_at(w);
                if (k >= 0) begin
                    m_sync = 1; m_off = 3'(k); m_mode = M_LOCKED;
                end else if (m_mode == M_PEND) begin
                    m_err = 1; m_mode = M_ZERO;
                end else if (d != 8'h00) begin
                    m_mode = M_PEND;
                end
            end else begin
                m_data = 8'((w >> m_off) & 16'h00FF);
                m_vld  = 1;
            end
            m_run = nrun;
        end
        m_zd   = (m_mode == M_ARMED) || (m_mode == M_PEND);
        m_prev = d;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".zd"},   16'(bus.Zero_Detected), 16'(m_zd));
        chk({tag, ".sync"}, 16'(bus.RxSyncHS),      16'(m_sync));
        chk({tag, ".err"},  16'(bus.SyncErr),       16'(m_err));
        chk({tag, ".off"},  16'(bus.Offset),        16'(m_off));
        chk({tag, ".data"}, 16'(bus.RxDataHS),      16'(m_data));
        chk({tag, ".vld"},  16'(bus.RxValidHS),     16'(m_vld));
    endtask

    task automatic cycle(input logic en, input logic [7:0] d, input string tag);
        bus.Enable = en;
        bus.DataHS = d;
        model_step(en, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".zd"},   16'(bus.Zero_Detected), 16'h0);
        chk({tag, ".sync"}, 16'(bus.RxSyncHS),      16'h0);
        chk({tag, ".err"},  16'(bus.SyncErr),       16'h0);
        chk({tag, ".off"},  16'(bus.Offset),        16'h0);
        chk({tag, ".data"}, 16'(bus.RxDataHS),      16'h0);
        chk({tag, ".vld"},  16'(bus.RxValidHS),     16'h0);
    endtask

    initial begin
        logic [63:0] s;
        int          k;
        bus.Enable = 1'b0;
        bus.DataHS = 8'h00;
        model_reset();

        // Reset held with random traffic
        for (int i = 0; i < 4; i++) begin
            bus.Enable = 1'($urandom);
            bus.DataHS = 8'($urandom);
            @(posedge clk);
            #1;
            check_all_zero("rst");
        end
        bus.Enable = 1'b0;
        rst_n = 1'b1;
        cycle(0, 8'h00, "en0");
        cycle(0, 8'h00, "en0");
        check_all_zero("en0");

        // One zero byte arms the search
        cycle(1, 8'h00, "t1");
        chk("t1.zd_const", 16'(bus.Zero_Detected), 16'h1);
        cycle(1, 8'hB8, "t1");
        cycle(1, 8'h5A, "t1");
        chk("t1.sync_const", 16'(bus.RxSyncHS), 16'h1);
        chk("t1.off_const",  16'(bus.Offset),   16'h0);
        cycle(1, 8'h33, "t1");
        chk("t1.data_const", 16'(bus.RxDataHS),  16'h5A);
        chk("t1.vld_const",  16'(bus.RxValidHS), 16'h1);
        chk("t1.sync_gone",  16'(bus.RxSyncHS),  16'h0);
        cycle(0, 8'h00, "t1");
        cycle(0, 8'h00, "t1");

        // Leader straddling two bytes at offset 3
        cycle(1, 8'h00, "t2");
        cycle(1, 8'hC0, "t2");
        cycle(1, 8'h05, "t2");
        chk("t2.sync_const", 16'(bus.RxSyncHS), 16'h1);
        chk("t2.off_const",  16'(bus.Offset),   16'h3);
        cycle(1, 8'hD0, "t2");
        cycle(1, 8'h02, "t2");
        chk("t2.data_const", 16'(bus.RxDataHS), 16'h5A);
        // Enable drop while locked
        cycle(0, 8'h77, "t2");
        chk("t2.vld_drop",   16'(bus.RxValidHS), 16'h0);
        chk("t2.off_hold",   16'(bus.Offset),    16'h3);
        cycle(0, 8'h00, "t2");

        // Garbage after arming
        cycle(1, 8'h00, "t3");
        cycle(1, 8'h01, "t3");
        chk("t3.zd_pend", 16'(bus.Zero_Detected), 16'h1);
        cycle(1, 8'hFE, "t3");
        chk("t3.err_const", 16'(bus.SyncErr),       16'h1);
        chk("t3.zd_fall",   16'(bus.Zero_Detected), 16'h0);
        cycle(0, 8'h00, "t3");
        cycle(0, 8'h00, "t3");

        // Single-bit-error leader
        cycle(1, 8'h00, "t4");
        cycle(1, 8'hB9, "t4");
        cycle(1, 8'h00, "t4");
`ifdef SYNC_1BIT_ERR_TOL_EN
        chk("t4.sync_const", 16'(bus.RxSyncHS), 16'h1);
`else
        chk("t4.err_const",  16'(bus.SyncErr),  16'h1);
`endif
        cycle(0, 8'h00, "t4");

        // Asynchronous reset mid-packet
        cycle(1, 8'h00, "t5");
        cycle(1, 8'hB8, "t5");
        cycle(1, 8'h11, "t5");
        cycle(1, 8'h22, "t5");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5.arst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 8'h00, "t5");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 12; i++)
                    cycle($urandom_range(0, 15) != 0,
                          ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom), "rnd");
            end else begin
                k = $urandom_range(0, 7);
                s = 64'(PAT) << (16 + k);
                s = s | (64'($urandom) << (24 + k));
                if ($urandom_range(0, 3) == 0) s = s ^ (64'h1 << (16 + k + $urandom_range(0, 7)));
                for (int i = 0; i < $urandom_range(0, 2); i++) cycle(1, 8'h00, "pkt");
                for (int i = 0; i < 8; i++) cycle(1, s[8*i +: 8], "pkt");
                for (int i = 0; i < $urandom_range(0, 3); i++) cycle(1, 8'($urandom), "pkt");
                cycle(0, 8'($urandom), "pkt");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
